// File: rtl/sha_result_collector.sv
// Tags each accepted double hash from a pipelined SHA core with nonce and block id, filters by difficulty, queues passes.
// Optional macro SHA_RESULT_COLLECTOR_HASH_OUT_EN stores the full hash per FIFO entry and presents it on found_hash.
module sha_result_collector #(
  parameter logic [31:0] PROCESSORINDEX = 32'd0,
  parameter logic [31:0] NUMPROCESSORS  = 32'd1,
  parameter int          FIFO_DEPTH     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             output_valid,
  input  logic             newblock_i,
  input  logic [7:0][31:0] doublehash,
  input  logic [31:0]      difficulty,
  output logic             found_valid,
  input  logic             found_ready,
  output logic [31:0]      found_nonce,
  output logic [7:0]       found_block,
  output logic [7:0][31:0] found_hash,
  output logic             overflow,
  output logic             exhausted
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  function automatic logic hash_passes(input logic [31:0] h7, input logic [31:0] diff);
    logic [31:0] check;
    check = {h7[7:0], h7[15:8], h7[23:16], h7[31:24]};
    return check <= diff;
  endfunction

  logic          armed_q, armed_d, exh_q, exh_d;
  logic [31:0]   next_q, next_d;
  logic [7:0]    blk_q, blk_d;
  logic          accept;
  logic [31:0]   res_nonce;
  logic [32:0]   sum;

  always_comb begin
    armed_d   = armed_q;
    exh_d     = exh_q;
    next_d    = next_q;
    blk_d     = blk_q;
    accept    = 1'b0;
    res_nonce = next_q;
    sum       = 33'd0;
    if (output_valid) begin
      if (newblock_i) begin
        accept    = 1'b1;
        res_nonce = PROCESSORINDEX;
        sum       = {1'b0, PROCESSORINDEX} + {1'b0, NUMPROCESSORS};
        next_d    = sum[31:0];
        exh_d     = sum[32];
        blk_d     = blk_q + 8'd1;
        armed_d   = 1'b1;
      end else if (armed_q && !exh_q) begin
        accept    = 1'b1;
        sum       = {1'b0, next_q} + {1'b0, NUMPROCESSORS};
        next_d    = sum[31:0];
        exh_d     = sum[32];
      end
    end
  end

  // Stage 1: accepted result registered with its pass flag
  logic          vld_p1_q;
  logic          pass_p1_q;
  logic [31:0]   nonce_p1_q;
  logic [7:0]    blk_p1_q;
`ifdef SHA_RESULT_COLLECTOR_HASH_OUT_EN
  logic [7:0][31:0] hash_p1_q;
`else
  logic          unused_hash;
  assign unused_hash = ^doublehash[6:0];
`endif

  always_ff @(posedge clk) begin
    pass_p1_q  <= hash_passes(doublehash[7], difficulty);
    nonce_p1_q <= res_nonce;
    blk_p1_q   <= blk_d;
`ifdef SHA_RESULT_COLLECTOR_HASH_OUT_EN
    hash_p1_q  <= doublehash;
`endif
  end

  // Stage 2: FIFO write of passing results, simultaneous pop allowed when full
  logic [31:0]   mem_nonce [FIFO_DEPTH];
  logic [7:0]    mem_blk   [FIFO_DEPTH];
`ifdef SHA_RESULT_COLLECTOR_HASH_OUT_EN
  logic [7:0][31:0] mem_hash [FIFO_DEPTH];
`endif
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push, pop, full, wr_en;

  always_comb begin
    push       = vld_p1_q && pass_p1_q;
    pop        = (count_q != '0) && found_ready;
    full       = (count_q == CW'(FIFO_DEPTH));
    wr_en      = push && (!full || pop);
    overflow_d = overflow_q || (push && full && !pop);
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_nonce[wr_ptr_q] <= nonce_p1_q;
      mem_blk[wr_ptr_q]   <= blk_p1_q;
`ifdef SHA_RESULT_COLLECTOR_HASH_OUT_EN
      mem_hash[wr_ptr_q]  <= hash_p1_q;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q    <= 1'b0;
      exh_q      <= 1'b0;
      next_q     <= '0;
      blk_q      <= '0;
      vld_p1_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      armed_q    <= armed_d;
      exh_q      <= exh_d;
      next_q     <= next_d;
      blk_q      <= blk_d;
      vld_p1_q   <= accept;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Head data is gated by occupancy so outputs read zero whenever the FIFO is empty
  assign found_valid = (count_q != '0);
  assign found_nonce = found_valid ? mem_nonce[rd_ptr_q] : '0;
  assign found_block = found_valid ? mem_blk[rd_ptr_q] : '0;
`ifdef SHA_RESULT_COLLECTOR_HASH_OUT_EN
  assign found_hash  = found_valid ? mem_hash[rd_ptr_q] : '0;
`else
  assign found_hash  = '0;
`endif
  assign overflow    = overflow_q;
  assign exhausted   = exh_q;

endmodule
